register_serializer: RTL

REGISTER_SERIALIZER -- requirements
Module: register_serializer

---
 rtl/register_serializer.sv | 88 ++++++++
 1 files changed

// File: rtl/register_serializer.sv
// register_serializer: loads a WIDTH-bit parallel word and shifts it out
// MSB first over a valid/ready serial handshake, then pulses done for one
// cycle before returning to idle. Every output is decoded from registered
// state, so the serial outputs have no combinational path from the load side.
module register_serializer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_enable,
  input  logic [WIDTH-1:0] data_in,
  output logic             load_ready,
  output logic             ser_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             busy,
  output logic             done
);

  // Counter only has to hold WIDTH-1, the index of the last bit
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state logic: load in idle, shift on each accepted bit, one done cycle
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (write_enable) begin
          shift_d = data_in;
          count_d = LAST_IDX;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ser_ready) begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          if (count_q == '0) begin
            state_d = ST_DONE;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        shift_d = '0;
        count_d = '0;
      end
    endcase
  end

  // State, shift register and bit counter, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

  // Output decode from registered state only; ser_data is forced low when not valid
  always_comb begin
    load_ready = (state_q == ST_IDLE);
    ser_valid  = (state_q == ST_SHIFT);
    busy       = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    done       = (state_q == ST_DONE);
    ser_data   = (state_q == ST_SHIFT) && shift_q[WIDTH-1];
  end

endmodule
